// File: rtl/ccc_cfg_pkg.sv
// Shared types and constants for the CCC APB configuration master.
package ccc_cfg_pkg;

  localparam int ADDR_W           = 6;
  localparam int DATA_W           = 8;
  localparam int BUSY_TIMEOUT_DEF = 256;
  localparam int LOCK_TIMEOUT_DEF = 4096;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_BUSY,
    ST_SETUP,
    ST_ACCESS,
    ST_WAIT_LOCK,
    ST_RESP
  } state_t;

endpackage

// File: rtl/ccc_sync2.sv
// Two-flop synchronizer for a single asynchronous level, cleared on reset.
module ccc_sync2 (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;
  logic r_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_meta <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      r_q    <= r_meta;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ccc_apb_cfg_master.sv
// Single-command APB initiator for the CCC config port: waits for BUSY low,
// issues one SETUP/ACCESS pair, optionally waits for PLL re-lock, then pulses a response.
module ccc_apb_cfg_master
  import ccc_cfg_pkg::*;
#(
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF
) (
  input  logic              i_pclk,
  input  logic              i_reset,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic              i_cmd_lockwait,
  input  logic [ADDR_W-1:0] i_cmd_addr,
  input  logic [DATA_W-1:0] i_cmd_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_rsp_err,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [ADDR_W-1:0] o_paddr,
  output logic [DATA_W-1:0] o_pwdata,
  input  logic [DATA_W-1:0] i_prdata,
  input  logic              i_busy,
  input  logic              i_lock,
  output logic              o_cfg_locked,
  input  logic              i_clr_lock_lost,
  output logic              o_lock_lost
);

  localparam int TMAX    = (BUSY_TIMEOUT > LOCK_TIMEOUT) ? BUSY_TIMEOUT : LOCK_TIMEOUT;
  localparam int CNT_W   = $clog2(TMAX);
  localparam logic [CNT_W-1:0] CNT_SAT   = CNT_W'(TMAX - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_TIMEOUT - 1);

  state_t            r_state;
  state_t            w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_write;
  logic              r_lockwait;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;
  logic              r_locked_d;
  logic              r_lock_lost;
  logic              w_cfg_locked;
  logic              w_set_err;
  logic              w_lock_fall;

  ccc_sync2 u_lock_sync (
    .i_clk (i_pclk),
    .i_rst (i_reset),
    .i_d   (i_lock),
    .o_q   (w_cfg_locked)
  );

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  // APB strobes are decoded from state so a reset drops them without waiting for a clock.
  always_comb begin
    w_next      = r_state;
    w_set_err   = 1'b0;
    o_cmd_ready = 1'b0;
    o_psel      = 1'b0;
    o_penable   = 1'b0;
    o_rsp_valid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        o_cmd_ready = !i_reset;
        if (i_cmd_valid) w_next = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (!i_busy) begin
          w_next = ST_SETUP;
        end else if (r_cnt == BUSY_LAST) begin
          w_next    = ST_RESP;
          w_set_err = 1'b1;
        end
      end
      ST_SETUP: begin
        o_psel = 1'b1;
        w_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        o_psel    = 1'b1;
        o_penable = 1'b1;
        w_next    = (r_write && r_lockwait) ? ST_WAIT_LOCK : ST_RESP;
      end
      ST_WAIT_LOCK: begin
        if (w_cfg_locked) begin
          w_next = ST_RESP;
        end else if (r_cnt == LOCK_LAST) begin
          w_next    = ST_RESP;
          w_set_err = 1'b1;
        end
      end
      ST_RESP: begin
        o_rsp_valid = 1'b1;
        w_next      = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  // Counts cycles spent in the current state; restarts on any state change.
  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset)                 r_cnt <= '0;
    else if (w_next != r_state)  r_cnt <= '0;
    else if (r_cnt != CNT_SAT)   r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_write    <= 1'b0;
      r_lockwait <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_pwrite   <= 1'b0;
      r_paddr    <= '0;
      r_pwdata   <= '0;
      r_rdata    <= '0;
      r_err      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && i_cmd_valid) begin
        r_write    <= i_cmd_write;
        r_lockwait <= i_cmd_lockwait;
        r_addr     <= i_cmd_addr;
        r_wdata    <= i_cmd_wdata;
        r_rdata    <= '0;
        r_err      <= 1'b0;
      end
      if (r_state == ST_WAIT_BUSY && w_next == ST_SETUP) begin
        r_pwrite <= r_write;
        r_paddr  <= r_addr;
        r_pwdata <= r_wdata;
      end
      if (r_state == ST_ACCESS && !r_write) r_rdata <= i_prdata;
      if (w_set_err) r_err <= 1'b1;
    end
  end

  // A lock drop during WAIT_LOCK is the expected consequence of the write, not a loss.
  assign w_lock_fall = r_locked_d && !w_cfg_locked && (r_state != ST_WAIT_LOCK);

  always_ff @(posedge i_pclk or posedge i_reset) begin
    if (i_reset) begin
      r_locked_d  <= 1'b0;
      r_lock_lost <= 1'b0;
    end else begin
      r_locked_d <= w_cfg_locked;
      if (w_lock_fall)          r_lock_lost <= 1'b1;
      else if (i_clr_lock_lost) r_lock_lost <= 1'b0;
    end
  end

  assign o_pwrite     = r_pwrite;
  assign o_paddr      = r_paddr;
  assign o_pwdata     = r_pwdata;
  assign o_rsp_rdata  = r_rdata;
  assign o_rsp_err    = r_err;
  assign o_cfg_locked = w_cfg_locked;
  assign o_lock_lost  = r_lock_lost;

endmodule

// File: tb/tb_ccc_apb_cfg_master.sv
// Randomized self-checking bench for ccc_apb_cfg_master against a latency/outcome model.
module tb_ccc_apb_cfg_master;

  localparam int BT   = 256;
  localparam int LT   = 4096;
  localparam int MAXN = LT + 400;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid, cmd_ready, cmd_write, cmd_lockwait;
  logic [5:0] cmd_addr;
  logic [7:0] cmd_wdata;
  logic       rsp_valid, rsp_err;
  logic [7:0] rsp_rdata;
  logic       psel, penable, pwrite;
  logic [5:0] paddr;
  logic [7:0] pwdata, prdata;
  logic       busy, lock, cfg_locked, clr_lock_lost, lock_lost;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ccc_apb_cfg_master dut (
    .i_pclk          (clk),
    .i_reset         (rst),
    .i_cmd_valid     (cmd_valid),
    .o_cmd_ready     (cmd_ready),
    .i_cmd_write     (cmd_write),
    .i_cmd_lockwait  (cmd_lockwait),
    .i_cmd_addr      (cmd_addr),
    .i_cmd_wdata     (cmd_wdata),
    .o_rsp_valid     (rsp_valid),
    .o_rsp_rdata     (rsp_rdata),
    .o_rsp_err       (rsp_err),
    .o_psel          (psel),
    .o_penable       (penable),
    .o_pwrite        (pwrite),
    .o_paddr         (paddr),
    .o_pwdata        (pwdata),
    .i_prdata        (prdata),
    .i_busy          (busy),
    .i_lock          (lock),
    .o_cfg_locked    (cfg_locked),
    .i_clr_lock_lost (clr_lock_lost),
    .o_lock_lost     (lock_lost)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // dl: 0 = lock never drops, >0 = lock low for dl cycles, <0 = lock never returns.
  task automatic run_cmd(input bit wr, input bit lw, input logic [5:0] addr,
                         input logic [7:0] wd, input logic [7:0] rd,
                         input int bc, input int dl);
    int  exp_n, exp_acc, d, n, setups, accs, setup_n;
    bit  exp_err, done, waits_lock;
    logic [7:0] exp_rdata, acc_wdata;
    logic [5:0] acc_addr;
    logic acc_write;

    // Reference model: outcome and response cycle (edges after the accept edge).
    waits_lock = wr && lw && (bc < BT);
    if (bc >= BT) begin
      exp_n = BT + 1; exp_err = 1'b1; exp_acc = 0;
    end else if (wr && lw) begin
      exp_acc = 1;
      d = (dl < 0) ? LT + 1000 : dl;
      if (d <= LT - 1) begin exp_n = bc + 5 + d; exp_err = 1'b0; end
      else             begin exp_n = bc + 4 + LT; exp_err = 1'b1; end
    end else begin
      exp_n = bc + 4; exp_err = 1'b0; exp_acc = 1;
    end
    exp_rdata = (wr || bc >= BT) ? 8'h00 : rd;

    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = wr; cmd_lockwait = lw;
    cmd_addr = addr; cmd_wdata = wd; prdata = rd; busy = (bc > 0);
    chk("cmd_ready_before_accept", cmd_ready, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 1; done = 1'b0; setups = 0; accs = 0; setup_n = -1;
    acc_addr = '0; acc_wdata = '0; acc_write = 1'b0;
    while (!done && n <= MAXN) begin
      busy = (n <= bc);
      if (waits_lock && dl != 0 && n == bc + 2) lock = 1'b0;
      if (waits_lock && dl > 0 && n == bc + 2 + dl) lock = 1'b1;
      if (psel && !penable) begin setups++; setup_n = n; end
      if (psel && penable) begin
        accs++; acc_addr = paddr; acc_write = pwrite; acc_wdata = pwdata;
      end
      if (rsp_valid) done = 1'b1;
      else begin n++; @(negedge clk); end
    end
    chk("rsp_latency", n, exp_n);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_rdata", rsp_rdata, exp_rdata);
    chk("setup_count", setups, exp_acc);
    chk("access_count", accs, exp_acc);
    if (exp_acc == 1) begin
      chk("setup_cycle", setup_n, bc + 2);
      chk("access_paddr", acc_addr, addr);
      chk("access_pwrite", acc_write, wr);
      chk("access_pwdata", acc_wdata, wd);
      chk("paddr_held", paddr, addr);
    end
    @(negedge clk);
    chk("rsp_single_pulse", rsp_valid, 0);
    chk("cmd_ready_after_rsp", cmd_ready, 1);
    lock = 1'b1; busy = 1'b0;
    repeat (4) @(negedge clk);
    chk("lock_lost_after_cmd", lock_lost, 0);
  endtask

  initial begin
    int cnt;
    rst = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_lockwait = 1'b0;
    cmd_addr = '0; cmd_wdata = '0; prdata = '0; busy = 1'b0; lock = 1'b1;
    clr_lock_lost = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_cmd_ready", cmd_ready, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_cfg_locked", cfg_locked, 0);
    chk("rst_lock_lost", lock_lost, 0);
    rst = 1'b0;
    #1 chk("cmd_ready_after_release", cmd_ready, 1);
    repeat (4) @(negedge clk);
    chk("cfg_locked_synced", cfg_locked, 1);

    run_cmd(1'b0, 1'b0, 6'h05, 8'h00, 8'hA7, 0, 0);
    run_cmd(1'b1, 1'b1, 6'h12, 8'h3C, 8'h00, 0, 100);
    run_cmd(1'b0, 1'b0, 6'h2A, 8'h00, 8'h55, 300, 0);
    run_cmd(1'b0, 1'b0, 6'h2B, 8'h00, 8'h66, 255, 0);
    run_cmd(1'b1, 1'b0, 6'h2C, 8'h77, 8'h00, 256, 0);
    run_cmd(1'b1, 1'b1, 6'h01, 8'h99, 8'h00, 0, -1);
    run_cmd(1'b1, 1'b1, 6'h02, 8'h5A, 8'h00, 1, LT - 1);
    run_cmd(1'b1, 1'b1, 6'h03, 8'hC3, 8'h00, 2, 0);

    for (int i = 0; i < 24; i++) begin
      int sel, bc, dl;
      sel = $urandom_range(0, 9);
      if (sel <= 5)      bc = $urandom_range(0, 3);
      else if (sel <= 7) bc = $urandom_range(4, 20);
      else if (sel == 8) bc = BT - 1;
      else               bc = BT;
      dl = $urandom_range(0, 30);
      run_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 6'($urandom),
              8'($urandom), 8'($urandom), bc, dl);
    end

    // Sticky loss-of-lock while idle.
    @(negedge clk); lock = 1'b0;
    @(negedge clk); chk("lost_m1", lock_lost, 0);
    @(negedge clk); chk("lost_m2", lock_lost, 0);
    @(negedge clk); chk("lost_m3", lock_lost, 1);
    chk("cfg_locked_low", cfg_locked, 0);
    lock = 1'b1;
    repeat (4) @(negedge clk);
    chk("lost_sticky", lock_lost, 1);
    lock = 1'b0;
    @(negedge clk);
    @(negedge clk); clr_lock_lost = 1'b1;
    @(negedge clk); chk("lost_set_wins", lock_lost, 1);
    @(negedge clk); clr_lock_lost = 1'b0;
    chk("lost_cleared", lock_lost, 0);
    lock = 1'b1;
    repeat (4) @(negedge clk);

    // Reset during ACCESS.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_lockwait = 1'b0;
    cmd_addr = 6'h33; prdata = 8'hE1; busy = 1'b0;
    @(negedge clk); cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_psel", psel, 1);
    chk("pre_rst_penable", penable, 1);
    rst = 1'b1;
    #1;
    chk("async_psel", psel, 0);
    chk("async_penable", penable, 0);
    chk("async_rsp_valid", rsp_valid, 0);
    @(negedge clk); rst = 1'b0;
    #1 chk("cmd_ready_post_abort", cmd_ready, 1);
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid || psel) cnt++;
    end
    chk("no_rsp_after_abort", cnt, 0);
    chk("lost_after_abort", lock_lost, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
